wb_retire_buf: RTL and testbench



---
 rtl/simplerisc_pkg.sv | 40 ++++
 rtl/wb_fifo.sv | 70 +++++++
 rtl/wb_retire_buf.sv | 125 ++++++++++++
 tb/tb_wb_retire_buf.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions: default widths, writeback entry layout and
// the result-select decode used by the retire stage.
package simplerisc_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NREG_DEF     = 16;
  localparam int unsigned LINK_REG_DEF = 15;
  localparam int unsigned PC_INC_DEF   = 4;

  typedef struct packed {
    logic [$clog2(NREG_DEF)-1:0] addr;
    logic [XLEN_DEF-1:0]         data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SelAlu,
    SelLd,
    SelCall
  } wb_sel_e;

  typedef struct packed {
    logic    legal;
    wb_sel_e sel;
  } wb_dec_t;

  // A load that is also a call has no defined result and is rejected.
  function automatic wb_dec_t wb_decode(input logic is_ld, input logic is_call);
    wb_dec_t d;
    d.legal = !(is_ld && is_call);
    if (is_call) begin
      d.sel = SelCall;
    end else if (is_ld) begin
      d.sel = SelLd;
    end else begin
      d.sel = SelAlu;
    end
    return d;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular write buffer; exposes its storage, per-entry valid bits and the
// tail pointer so the parent can run a newest-first search.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [WIDTH-1:0]            rdata,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            valid,
  output logic [$clog2(DEPTH)-1:0]    wptr
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               rptr_q, wptr_q;
  logic [PW:0]                 count_q, count_d;
  logic [PW-1:0]               off;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rptr_q];
  assign entries = mem_q;
  assign wptr    = wptr_q;

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rptr_q;
      valid[i] = ({1'b0, off} < count_q);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_retire_buf.sv
// Writeback/retire stage: result select, buffered register-file writes,
// newest-first forwarding lookup, retire counter and illegal-flag latch.
module wb_retire_buf
  import simplerisc_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned LINK_REG = LINK_REG_DEF,
  parameter int unsigned PC_INC   = PC_INC_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNTW     = 32,
  localparam int unsigned RW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_wb,
  input  logic            in_is_ld,
  input  logic            in_is_call,
  input  logic [RW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_ld,
  output logic            rf_we,
  output logic [RW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            rf_ready,
  input  logic [RW-1:0]   q_addr,
  output logic            q_hit,
  output logic [XLEN-1:0] q_data,
  output logic [CNTW-1:0] retired,
  output logic            err_illegal
);

  localparam int unsigned EW = RW + XLEN;
  localparam int unsigned PW = $clog2(DEPTH);

  wb_dec_t                  dec;
  logic [RW-1:0]            wr_addr;
  logic [XLEN-1:0]          wr_data;
  logic                     accept, push, pop, retire_nonwb;
  logic                     full, empty;
  logic [EW-1:0]            head;
  logic [DEPTH-1:0][EW-1:0] entries;
  logic [DEPTH-1:0]         valid;
  logic [PW-1:0]            wptr, fwd_idx;
  logic [1:0]               inc;
  logic [CNTW-1:0]          retired_q;
  logic                     err_q;

  assign dec = wb_decode(in_is_ld, in_is_call);

  always_comb begin
    wr_addr = in_rd;
    wr_data = in_alu;
    unique case (dec.sel)
      SelLd:   wr_data = in_ld;
      SelCall: begin
        wr_addr = RW'(LINK_REG);
        wr_data = in_pc + XLEN'(PC_INC);
      end
      default: wr_data = in_alu;
    endcase
  end

  assign in_ready     = !full || (rf_we && rf_ready);
  assign accept       = in_valid && in_ready;
  assign push         = accept && dec.legal && in_is_wb;
  assign retire_nonwb = accept && dec.legal && !in_is_wb;
  assign pop          = rf_we && rf_ready;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wdata   ({wr_addr, wr_data}),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .rdata   (head),
    .entries (entries),
    .valid   (valid),
    .wptr    (wptr)
  );

  assign rf_we    = !empty;
  assign rf_waddr = empty ? '0 : head[EW-1:XLEN];
  assign rf_wdata = empty ? '0 : head[XLEN-1:0];

  // Walk back from the slot just behind the tail so the newest match wins.
  always_comb begin
    q_hit   = 1'b0;
    q_data  = '0;
    fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = wptr - PW'(k + 1);
      if (!q_hit && valid[fwd_idx] && (entries[fwd_idx][EW-1:XLEN] == q_addr)) begin
        q_hit  = 1'b1;
        q_data = entries[fwd_idx][XLEN-1:0];
      end
    end
  end

  assign inc = {1'b0, retire_nonwb} + {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      retired_q <= retired_q + CNTW'(inc);
      if (accept && !dec.legal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign retired     = retired_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_wb_retire_buf.sv
// Scoreboard bench: stimulus pushes expected register-file writes, a monitor
// pops and compares them on every handshake.
module tb_wb_retire_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_is_wb, in_is_ld, in_is_call;
  logic [3:0]  in_rd, q_addr;
  logic [31:0] in_pc, in_alu, in_ld;
  logic        rf_ready;
  logic        in_ready, rf_we, q_hit, err_illegal;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata, q_data, retired;
  logic        s_in_ready, s_rf_we, s_q_hit, s_err;
  logic [3:0]  s_rf_waddr;
  logic [31:0] s_rf_wdata, s_q_data;
  logic [3:0]  s_retired;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_ret;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wb_retire_buf dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
    .in_is_wb (in_is_wb), .in_is_ld (in_is_ld), .in_is_call (in_is_call),
    .in_rd (in_rd), .in_pc (in_pc), .in_alu (in_alu), .in_ld (in_ld),
    .rf_we (rf_we), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata), .rf_ready (rf_ready),
    .q_addr (q_addr), .q_hit (q_hit), .q_data (q_data),
    .retired (retired), .err_illegal (err_illegal)
  );

  wb_retire_buf #(.CNTW (4)) dut_s (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (s_in_ready),
    .in_is_wb (in_is_wb), .in_is_ld (in_is_ld), .in_is_call (in_is_call),
    .in_rd (in_rd), .in_pc (in_pc), .in_alu (in_alu), .in_ld (in_ld),
    .rf_we (s_rf_we), .rf_waddr (s_rf_waddr), .rf_wdata (s_rf_wdata), .rf_ready (rf_ready),
    .q_addr (q_addr), .q_hit (s_q_hit), .q_data (s_q_data),
    .retired (s_retired), .err_illegal (s_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted register-file write must match the queue head.
  always @(negedge clk) begin
    if (rst_n && rf_we && rf_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none",
                 rf_waddr, rf_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(rf_waddr), 64'(e.addr));
        chk("wr_data", 64'(rf_wdata), 64'(e.data));
        exp_ret = exp_ret + 1;
      end
    end
  end

  task automatic send(input logic wb, input logic ld, input logic call, input logic [3:0] rd,
                      input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] ldv,
                      output int waited);
    exp_t e;
    in_is_wb = wb; in_is_ld = ld; in_is_call = call;
    in_rd = rd; in_pc = pc; in_alu = alu; in_ld = ldv;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
    end else if (!(ld && call)) begin
      if (wb) begin
        e.addr = call ? 4'd15 : rd;
        e.data = call ? pc + 32'd4 : (ld ? ldv : alu);
        sb.push_back(e);
      end else begin
        exp_ret = exp_ret + 1;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; in_is_wb = 1'b0; in_is_ld = 1'b0; in_is_call = 1'b0;
    in_rd = '0; in_pc = '0; in_alu = '0; in_ld = '0; rf_ready = 1'b0; q_addr = '0;
    exp_ret = '0;
    #12;
    chk("rst_rf_we", 64'(rf_we), 0);
    chk("rst_waddr", 64'(rf_waddr), 0);
    chk("rst_wdata", 64'(rf_wdata), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_retired", 64'(retired), 0);
    chk("rst_err", 64'(err_illegal), 0);
    chk("rst_q_hit", 64'(q_hit), 0);
    chk("rst_q_data", 64'(q_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back with the register file always ready.
    rf_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 4'd3, 32'h0, 32'h11, 32'h0, w);
    chk("latency_rf_we", 64'(rf_we), 1);
    send(1'b1, 1'b1, 1'b0, 4'd4, 32'h0, 32'h0, 32'h22, w);
    send(1'b1, 1'b0, 1'b1, 4'd1, 32'h100, 32'h0, 32'h0, w);
    drain();
    chk("b2b_retired", 64'(retired), 64'(exp_ret));
    chk("b2b_retired_abs", 64'(retired), 3);

    // Backpressure: fill, hold, then push-while-full with a simultaneous pop.
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, 1'b0, 1'b0, 4'(i), 32'h0, 32'h100 + 32'(i), 32'h0, w);
    end
    chk("full_in_ready", 64'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_waddr", 64'(rf_waddr), 1);
    chk("hold_wdata", 64'(rf_wdata), 64'h101);
    chk("hold_retired", 64'(retired), 64'(exp_ret));
    rf_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 4'd5, 32'h0, 32'h105, 32'h0, w);
    chk("full_push_pop_wait", 64'(w), 0);
    drain();
    chk("bp_retired", 64'(retired), 64'(exp_ret));

    // Forwarding: newest match wins, miss reads zero.
    rf_ready = 1'b0;
    send(1'b1, 1'b0, 1'b0, 4'd5, 32'h0, 32'hA, 32'h0, w);
    send(1'b1, 1'b0, 1'b0, 4'd7, 32'h0, 32'hB, 32'h0, w);
    send(1'b1, 1'b0, 1'b0, 4'd5, 32'h0, 32'hC, 32'h0, w);
    q_addr = 4'd5; #1;
    chk("fwd5_hit", 64'(q_hit), 1);
    chk("fwd5_data", 64'(q_data), 64'hC);
    q_addr = 4'd7; #1;
    chk("fwd7_data", 64'(q_data), 64'hB);
    q_addr = 4'd9; #1;
    chk("fwd9_hit", 64'(q_hit), 0);
    chk("fwd9_data", 64'(q_data), 0);
    rf_ready = 1'b1;
    drain();

    // Non-writeback and illegal flag combinations.
    send(1'b0, 1'b0, 1'b0, 4'd2, 32'h0, 32'h77, 32'h0, w);
    chk("nonwb_rf_we", 64'(rf_we), 0);
    chk("nonwb_retired", 64'(retired), 64'(exp_ret));
    send(1'b1, 1'b1, 1'b1, 4'd6, 32'h0, 32'h55, 32'h66, w);
    chk("illegal_err", 64'(err_illegal), 1);
    chk("illegal_rf_we", 64'(rf_we), 0);
    chk("illegal_retired", 64'(retired), 64'(exp_ret));
    send(1'b1, 1'b0, 1'b0, 4'd8, 32'h0, 32'h88, 32'h0, w);
    drain();
    chk("err_sticky", 64'(err_illegal), 1);
    chk("post_illegal_retired", 64'(retired), 64'(exp_ret));

    // Reset mid-traffic with three writes pending.
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b0, 1'b0, 4'(10 + i), 32'h0, 32'h200 + 32'(i), 32'h0, w);
    end
    rst_n = 1'b0;
    sb.delete();
    exp_ret = '0;
    #1;
    chk("mid_rst_rf_we", 64'(rf_we), 0);
    chk("mid_rst_in_ready", 64'(in_ready), 1);
    chk("mid_rst_err", 64'(err_illegal), 0);
    chk("mid_rst_q_hit", 64'(q_hit), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rf_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_retired", 64'(retired), 0);
    chk("post_rst_rf_we", 64'(rf_we), 0);

    // Counter wrap on the 4-bit instance, then return-address wrap.
    for (int i = 0; i < 17; i++) begin
      send(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, w);
    end
    chk("wrap_small", 64'(s_retired), 64'(exp_ret[3:0]));
    chk("wrap_small_abs", 64'(s_retired), 1);
    chk("wrap_main", 64'(retired), 17);
    send(1'b1, 1'b0, 1'b1, 4'd2, 32'hFFFF_FFFC, 32'h0, 32'h0, w);
    chk("pcwrap_fwd_hit", 64'(q_hit), 0);
    drain();
    chk("pcwrap_retired", 64'(s_retired), 64'(exp_ret[3:0]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
